// File: rtl/fp_packer_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp_packer_pipe: two-stage RNE rounder / IEEE-754 packer with valid/ready   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fp_packer_pipe #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23,
    parameter int SAT    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic [EXP_W+1:0]        in_exp,
    input  logic [MANT_W-1:0]       in_mant,
    input  logic [2:0]              in_grs,
    input  logic                    in_is_nan,
    input  logic                    in_is_inf,
    input  logic                    in_is_zero,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W:0]   out_data,
    output logic [3:0]              out_flags,
    input  logic                    flags_clr,
    output logic [3:0]              sticky_flags
);

    localparam int W = 1 + EXP_W + MANT_W;
    localparam logic [EXP_W+2:0] OVF_EXP = {3'b000, {EXP_W{1'b1}}};

    // Stage 1 state
    logic               s1_valid_q, s1_valid_d;
    logic               s1_sign_q,  s1_sign_d;
    logic               s1_nan_q,   s1_nan_d;
    logic               s1_inf_q,   s1_inf_d;
    logic               s1_zero_q,  s1_zero_d;
    logic               s1_uf_q,    s1_uf_d;
    logic               s1_of_q,    s1_of_d;
    logic               s1_nx_q,    s1_nx_d;
    logic [EXP_W-1:0]   s1_exp_q,   s1_exp_d;
    logic [MANT_W-1:0]  s1_mant_q,  s1_mant_d;

    // Stage 2 state
    logic               s2_valid_q, s2_valid_d;
    logic [W-1:0]       data_q,     data_d;
    logic [3:0]         flags_q,    flags_d;
    logic [3:0]         sticky_q,   sticky_d;

    logic               s1_adv, s2_adv, accept;
    logic               inc, exp_le0, ovf;
    logic [MANT_W:0]    mant_sum;
    logic [EXP_W+2:0]   exp_rnd;
    logic [W-1:0]       pack_data;
    logic [3:0]         pack_flags;

    // Rounding and range detection; one extra exponent bit keeps e'+carry from wrapping
    always_comb begin
        inc      = in_grs[2] & (in_grs[1] | in_grs[0] | in_mant[0]);
        mant_sum = {1'b0, in_mant} + {{MANT_W{1'b0}}, inc};
        exp_rnd  = {in_exp[EXP_W+1], in_exp} + {{(EXP_W+2){1'b0}}, mant_sum[MANT_W]};
        exp_le0  = in_exp[EXP_W+1] | (in_exp == '0);
        ovf      = !exp_le0 && (exp_rnd >= OVF_EXP);
    end

    always_comb begin
        pack_data  = '0;
        pack_flags = 4'b0000;
        if (s1_nan_q) begin
            pack_data  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};
            pack_flags = 4'b1000;
        end else if (s1_inf_q) begin
            pack_data  = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
        end else if (s1_zero_q) begin
            pack_data  = {s1_sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
        end else if (s1_uf_q) begin
            pack_data  = {s1_sign_q, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
            pack_flags = 4'b0011;
        end else if (s1_of_q) begin
            if (SAT != 0) begin
                pack_data = {s1_sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MANT_W{1'b1}}};
            end else begin
                pack_data = {s1_sign_q, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            end
            pack_flags = 4'b0101;
        end else begin
            pack_data  = {s1_sign_q, s1_exp_q, s1_mant_q};
            pack_flags = {3'b000, s1_nx_q};
        end
    end

    always_comb begin
        s2_adv   = !s2_valid_q | out_ready;
        s1_adv   = !s1_valid_q | s2_adv;
        in_ready = !rst & s1_adv;
        accept   = in_valid & in_ready;

        s1_valid_d = s1_adv ? accept : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_nan_d   = s1_nan_q;
        s1_inf_d   = s1_inf_q;
        s1_zero_d  = s1_zero_q;
        s1_uf_d    = s1_uf_q;
        s1_of_d    = s1_of_q;
        s1_nx_d    = s1_nx_q;
        s1_exp_d   = s1_exp_q;
        s1_mant_d  = s1_mant_q;
        if (accept) begin
            s1_sign_d = in_sign;
            s1_nan_d  = in_is_nan;
            s1_inf_d  = !in_is_nan & in_is_inf;
            s1_zero_d = !in_is_nan & !in_is_inf & in_is_zero;
            s1_uf_d   = exp_le0;
            s1_of_d   = ovf;
            s1_nx_d   = |in_grs;
            s1_exp_d  = exp_rnd[EXP_W-1:0];
            s1_mant_d = mant_sum[MANT_W-1:0];
        end

        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        data_d     = data_q;
        flags_d    = flags_q;
        if (s2_adv && s1_valid_q) begin
            data_d  = pack_data;
            flags_d = pack_flags;
        end

        // A handshake's flags survive a same-cycle clear
        sticky_d = flags_clr ? 4'b0000 : sticky_q;
        if (s2_valid_q && out_ready) begin
            sticky_d = sticky_d | flags_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_uf_q    <= 1'b0;
            s1_of_q    <= 1'b0;
            s1_nx_q    <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s2_valid_q <= 1'b0;
            data_q     <= '0;
            flags_q    <= 4'b0000;
            sticky_q   <= 4'b0000;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q  <= s1_sign_d;
            s1_nan_q   <= s1_nan_d;
            s1_inf_q   <= s1_inf_d;
            s1_zero_q  <= s1_zero_d;
            s1_uf_q    <= s1_uf_d;
            s1_of_q    <= s1_of_d;
            s1_nx_q    <= s1_nx_d;
            s1_exp_q   <= s1_exp_d;
            s1_mant_q  <= s1_mant_d;
            s2_valid_q <= s2_valid_d;
            data_q     <= data_d;
            flags_q    <= flags_d;
            sticky_q   <= sticky_d;
        end
    end

    assign out_valid    = s2_valid_q;
    assign out_data     = data_q;
    assign out_flags    = flags_q;
    assign sticky_flags = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_packer_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp_packer_pipe: directed bench for FP32 (SAT=0/1) and FP16 packers      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fp_packer_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // FP32 stimulus shared by the SAT=0 and SAT=1 instances
    logic        in_valid, in_sign, in_is_nan, in_is_inf, in_is_zero, out_ready, flags_clr;
    logic [9:0]  in_exp;
    logic [22:0] in_mant;
    logic [2:0]  in_grs;
    logic        in_ready, in_ready_s, out_valid, out_valid_s;
    logic [31:0] out_data, out_data_s;
    logic [3:0]  out_flags, out_flags_s, sticky, sticky_s;

    // FP16 instance
    logic        h_valid, h_sign, h_nan, h_inf, h_zero, h_out_ready, h_clr;
    logic [6:0]  h_exp;
    logic [9:0]  h_mant;
    logic [2:0]  h_grs;
    logic        h_in_ready, h_out_valid;
    logic [15:0] h_out_data;
    logic [3:0]  h_out_flags, h_sticky;

    int passes = 0;
    int fails  = 0;
    int total  = 0;
    int sent, recv, cyc;
    logic exp_rdy;

    logic [31:0] bp_data  [6] = '{32'h3F800000, 32'h3F800001, 32'h3F800002,
                                  32'h3F800003, 32'h00000000, 32'h3F800005};
    logic [3:0]  bp_flags [6] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h3, 4'h0};

    fp_packer_pipe #(.EXP_W(8), .MANT_W(23), .SAT(0)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .in_is_nan(in_is_nan), .in_is_inf(in_is_inf), .in_is_zero(in_is_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_flags(out_flags), .flags_clr(flags_clr), .sticky_flags(sticky)
    );

    fp_packer_pipe #(.EXP_W(8), .MANT_W(23), .SAT(1)) dut32s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .in_is_nan(in_is_nan), .in_is_inf(in_is_inf), .in_is_zero(in_is_zero),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_flags(out_flags_s), .flags_clr(flags_clr), .sticky_flags(sticky_s)
    );

    fp_packer_pipe #(.EXP_W(5), .MANT_W(10), .SAT(0)) dut16 (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_in_ready),
        .in_sign(h_sign), .in_exp(h_exp), .in_mant(h_mant), .in_grs(h_grs),
        .in_is_nan(h_nan), .in_is_inf(h_inf), .in_is_zero(h_zero),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .out_data(h_out_data),
        .out_flags(h_out_flags), .flags_clr(h_clr), .sticky_flags(h_sticky)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive32(input logic s, input logic [9:0] e, input logic [22:0] m,
                           input logic [2:0] g, input logic [2:0] sp);
        in_valid   = 1'b1;
        in_sign    = s;
        in_exp     = e;
        in_mant    = m;
        in_grs     = g;
        in_is_nan  = sp[2];
        in_is_inf  = sp[1];
        in_is_zero = sp[0];
    endtask

    // Sends one word into an empty pipe and checks the 2-cycle latency and result
    task automatic one32(input string tag, input logic s, input logic [9:0] e,
                         input logic [22:0] m, input logic [2:0] g, input logic [2:0] sp,
                         input logic [31:0] xd, input logic [31:0] xds, input logic [3:0] xf);
        drive32(s, e, m, g, sp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_v1"}, 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_v2"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, xd);
        chk({tag, "_flags"}, 32'(out_flags), 32'(xf));
        chk({tag, "_sat"}, out_data_s, xds);
    endtask

    task automatic one16(input string tag, input logic s, input logic [6:0] e,
                         input logic [9:0] m, input logic [2:0] g, input logic [2:0] sp,
                         input logic [15:0] xd, input logic [3:0] xf);
        h_valid = 1'b1;
        h_sign  = s;
        h_exp   = e;
        h_mant  = m;
        h_grs   = g;
        h_nan   = sp[2];
        h_inf   = sp[1];
        h_zero  = sp[0];
        @(posedge clk); #1;
        h_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_v"}, 32'(h_out_valid), 32'd1);
        chk({tag, "_data"}, 32'(h_out_data), 32'(xd));
        chk({tag, "_flags"}, 32'(h_out_flags), 32'(xf));
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; in_grs = '0;
        in_is_nan = 1'b0; in_is_inf = 1'b0; in_is_zero = 1'b0;
        out_ready = 1'b1; flags_clr = 1'b0;
        h_valid = 1'b0; h_sign = 1'b0; h_exp = '0; h_mant = '0; h_grs = '0;
        h_nan = 1'b0; h_inf = 1'b0; h_zero = 1'b0; h_out_ready = 1'b1; h_clr = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        chk("rst_sticky", 32'(sticky), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // FP32 directed vectors; sp = {nan, inf, zero}
        one32("basic",  1'b0, 10'd127, 23'h000000, 3'b000, 3'b000, 32'h3F800000, 32'h3F800000, 4'h0);
        one32("rcarry", 1'b0, 10'd127, 23'h7FFFFF, 3'b100, 3'b000, 32'h40000000, 32'h40000000, 4'h1);
        one32("tie",    1'b0, 10'd127, 23'h000002, 3'b100, 3'b000, 32'h3F800002, 32'h3F800002, 4'h1);
        one32("rup",    1'b0, 10'd127, 23'h000001, 3'b110, 3'b000, 32'h3F800002, 32'h3F800002, 4'h1);
        one32("maxfin", 1'b0, 10'd254, 23'h7FFFFF, 3'b000, 3'b000, 32'h7F7FFFFF, 32'h7F7FFFFF, 4'h0);
        one32("minnrm", 1'b0, 10'd1,   23'h000000, 3'b000, 3'b000, 32'h00800000, 32'h00800000, 4'h0);
        one32("ovf",    1'b0, 10'd254, 23'h7FFFFF, 3'b110, 3'b000, 32'h7F800000, 32'h7F7FFFFF, 4'h5);
        one32("ovfneg", 1'b1, 10'd254, 23'h7FFFFF, 3'b110, 3'b000, 32'hFF800000, 32'hFF7FFFFF, 4'h5);
        one32("ovfexp", 1'b0, 10'd255, 23'h000000, 3'b000, 3'b000, 32'h7F800000, 32'h7F7FFFFF, 4'h5);
        one32("ovfbig", 1'b0, 10'h1FF, 23'h7FFFFF, 3'b100, 3'b000, 32'h7F800000, 32'h7F7FFFFF, 4'h5);
        one32("unf",    1'b1, 10'd0,   23'h000123, 3'b000, 3'b000, 32'h80000000, 32'h80000000, 4'h3);
        one32("unfneg", 1'b0, 10'h3FD, 23'h7FFFFF, 3'b111, 3'b000, 32'h00000000, 32'h00000000, 4'h3);
        one32("nan",    1'b1, 10'd127, 23'h000005, 3'b000, 3'b100, 32'h7FC00000, 32'h7FC00000, 4'h8);
        one32("infz",   1'b0, 10'd0,   23'h000000, 3'b000, 3'b011, 32'h7F800000, 32'h7F800000, 4'h0);
        one32("zero",   1'b1, 10'd254, 23'h7FFFFF, 3'b111, 3'b001, 32'h80000000, 32'h80000000, 4'h0);
        @(posedge clk); #1;
        chk("sticky_all", 32'(sticky), 32'hF);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("sticky_clr", 32'(sticky), 32'h0);

        // Backpressure stream: 6 words, out_ready low for cycles 2..5
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 6 && cyc < 40) begin
            out_ready = !(cyc >= 2 && cyc <= 5);
            if (sent < 6) begin
                drive32(1'b0, (sent == 4) ? 10'd0 : 10'd127, 23'(sent),
                        (sent == 2) ? 3'b001 : 3'b000, 3'b000);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            exp_rdy = ((sent - recv) < 2) || out_ready;
            chk("bp_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (in_valid && exp_rdy) sent++;
            if (out_valid && recv < 6) begin
                chk("bp_data", out_data, bp_data[recv]);
                chk("bp_flags", 32'(out_flags), 32'(bp_flags[recv]));
                if (out_ready) recv++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 32'(recv), 32'd6);
        chk("bp_sticky", 32'(sticky), 32'h3);

        // Clear and handshake in the same cycle: the new flags must remain
        one32("sameclr", 1'b0, 10'd127, 23'h000002, 3'b100, 3'b000, 32'h3F800002, 32'h3F800002, 4'h1);
        flags_clr = 1'b1;
        @(posedge clk); #1;
        flags_clr = 1'b0;
        chk("sameclr_sticky", 32'(sticky), 32'h1);

        // Reset with two words in flight
        out_ready = 1'b0;
        drive32(1'b0, 10'd127, 23'h000000, 3'b001, 3'b000);
        @(posedge clk); #1;
        drive32(1'b0, 10'd127, 23'h000001, 3'b000, 3'b000);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("inflight_v", 32'(out_valid), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sticky", 32'(sticky), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        chk("post_v0", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        chk("post_v1", 32'(out_valid), 32'd0);
        one32("post", 1'b0, 10'd128, 23'h000000, 3'b000, 3'b000, 32'h40000000, 32'h40000000, 4'h0);

        // FP16
        one16("h_basic",  1'b0, 7'd15, 10'h000, 3'b000, 3'b000, 16'h3C00, 4'h0);
        one16("h_rcarry", 1'b0, 7'd15, 10'h3FF, 3'b100, 3'b000, 16'h4000, 4'h1);
        one16("h_ovf",    1'b0, 7'd30, 10'h3FF, 3'b110, 3'b000, 16'h7C00, 4'h5);
        one16("h_unf",    1'b0, 7'd0,  10'h001, 3'b000, 3'b000, 16'h0000, 4'h3);
        one16("h_nan",    1'b1, 7'd15, 10'h000, 3'b000, 3'b100, 16'h7E00, 4'h8);
        @(posedge clk); #1;
        chk("h_sticky", 32'(h_sticky), 32'hF);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
`default_nettype wire
